mutex_arb_n: RTL
================

Name: mutex_arb_n

Overview:
- Parametrised N-channel mutual-exclusion element for the self-timed read-block interface logic. Synchronous successor to the two-channel mutex.
- Grants exactly one requester at a time using a 4-phase req/gnt handshake.
- Breaks ties with a round-robin pointer instead of a random delay, and inserts a programmable guard gap between successive owners.
- Sits between the block-read requesters and the shared resource.

Parameters:
- N, 4: number of request channels; legal range 2..16.
- GUARD, 1: idle cycles forced after a release before the next grant; legal range 0..15.
- TIMEOUT, 64: maximum cycles a grant may be held; used only with the optional feature; must be at least 2.
- IDW, derived localparam = clog2(N): width of the owner index.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  reset, synchronous, active-high.
- req  input  N  level requests, one per channel; 4-phase protocol.
- gnt  output  N  registered one-hot grant, or all zero.
- busy  output  1  high while any gnt bit is high.
- owner  output  IDW  index of the granted channel; holds its last value when busy=0.
- conflict  output  1  one-cycle pulse: more than one req bit was high on an arbitration edge.
- timeout_err  output  1  one-cycle pulse: a grant was revoked by timeout.

Behaviour:
- Reset (synchronous, active-high):
  - gnt=0, busy=0, owner=0, conflict=0, timeout_err=0.
  - State=IDLE, round-robin pointer ptr=0, guard counter=0.
  - Reset wins over every other event, including mid-grant; a revoked owner gets no notification.
- States: IDLE, GRANT, GAP.
- IDLE:
  - On each edge with req!=0, select the first set bit searching from ptr upward, wrapping modulo N.
  - That gnt bit goes high on this same edge, so gnt is visible one cycle after req is sampled high.
  - Set owner to the selected index; busy=1; go to GRANT.
  - If popcount(req)>1 on this edge, conflict=1 for one cycle.
  - With req=0: stay in IDLE, all outputs low.
- GRANT:
  - gnt[owner] stays high while req[owner]=1. Other req bits are ignored and not latched.
  - Sampling req[owner]=0 on an edge:
    - Clear gnt and busy on that edge.
    - Set ptr=(owner+1) mod N.
    - If GUARD>0, go to GAP and load the counter with GUARD. If GUARD=0, go to IDLE.
  - With GUARD=0 a new grant therefore appears no earlier than the second edge after release, so gnt is never high for two owners in adjacent cycles.
- GAP:
  - Decrement the counter every cycle. On the edge the counter reaches 1, go to IDLE.
  - No grants are issued and conflict is not evaluated.
- Requests:
  - Only levels are sampled; a req pulse that rises and falls entirely outside IDLE is lost.
  - Requesters must hold req until gnt is seen, then drop req to release.
- Invariants:
  - gnt is always one-hot or zero.
  - busy == |gnt.
  - owner is stable for the whole time busy=1.
- Wrap-around: ptr wraps from N-1 to 0. N need not be a power of two; an index of N or above is never produced.

Optional Feature:
- Macro MUTEX_ARB_TIMEOUT_EN.
- Defined:
  - A hold counter clears on grant and increments each cycle in GRANT.
  - When it reaches TIMEOUT with req[owner] still high:
    - Force gnt=0 and busy=0, pulse timeout_err for one cycle, set ptr=(owner+1) mod N, and enter GAP/IDLE exactly as for a normal release.
    - Mask the revoked channel from arbitration until its req is sampled low at least once.
- Not defined:
  - No hold counter and no mask.
  - timeout_err is tied to 0.
  - A grant is held indefinitely.

Test Plan:
- N=4, GUARD=1: reset asserted with req=4'b1111 -> all outputs 0. After deassert, req=4'b0101 -> next edge gnt=4'b0001, owner=0, conflict=1 for one cycle.
- Drop req[0] while req[2]=1 -> gnt=0 on the next edge, 1 GAP cycle, then gnt=4'b0100, owner=2. Drop req[2] with req=4'b0001 -> gnt=4'b0001 only after the gap.
- Round-robin: hold req=4'b1111 and have each owner release after 3 cycles -> grant order 0,1,2,3,0. No cycle has 2 gnt bits set. Each grant is separated by exactly 1 idle cycle.
- GUARD=0, N=3: owner=2 releases while req[0]=1 -> ptr wraps to 0, gnt=3'b001 two edges after release. owner is never 3.
- Reset mid-grant (gnt=4'b0010): assert reset one cycle -> gnt=0 and ptr=0 on that edge. After release with req=4'b0010 -> gnt=4'b0010 one cycle later.
- With MUTEX_ARB_TIMEOUT_EN, TIMEOUT=8: hold req[1] high -> gnt[1] drops after 8 GRANT cycles and timeout_err pulses once. req[1] is not regranted until it goes low then high. Without the macro, gnt[1] holds for 100 or more cycles and timeout_err stays 0.

Source files
------------

// File: rtl/mutex_arb_n.sv
// ---------------------------------------------------------------------------
// mutex_arb_n
// N-channel synchronous mutual-exclusion element for the block-read interface.
// Grants one requester at a time on a 4-phase req/gnt handshake. Ties are
// broken by a round-robin pointer. A programmable guard gap is inserted
// between successive owners.
//
// Optional feature (macro MUTEX_ARB_TIMEOUT_EN): a grant held for TIMEOUT
// cycles is revoked, timeout_err pulses, and the revoked channel is masked
// from arbitration until its req is seen low once.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   req[N]       level requests, one per channel
//   gnt[N]       registered one-hot grant (or zero)
//   busy         high while any gnt bit is high
//   owner[IDW]   index of the granted channel, holds when idle
//   conflict     one-cycle pulse: >1 req high on the granting edge
//   timeout_err  one-cycle pulse: a grant was revoked by timeout
// ---------------------------------------------------------------------------
module mutex_arb_n #(
    parameter  int unsigned N       = 4,
    parameter  int unsigned GUARD   = 1,
    parameter  int unsigned TIMEOUT = 64,
    localparam int unsigned IDW     = (N > 1) ? $clog2(N) : 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   gnt,
    output logic           busy,
    output logic [IDW-1:0] owner,
    output logic           conflict,
    output logic           timeout_err
);

    localparam int unsigned GCW = 4;
    localparam int unsigned TOW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    // Elaboration-time parameter range check
    if (N < 2 || N > 16 || GUARD > 15 || TIMEOUT < 2) begin : g_bad_param
        $error("mutex_arb_n: parameter out of legal range");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [GCW-1:0] gcnt_q, gcnt_d;
    logic [N-1:0]   gnt_q, gnt_d;
    logic           busy_q, busy_d;
    logic [IDW-1:0] owner_q, owner_d;
    logic           conflict_q, conflict_d;
    logic           terr_q, terr_d;

`ifdef MUTEX_ARB_TIMEOUT_EN
    logic [TOW-1:0] hold_q, hold_d;
    logic [N-1:0]   mask_q, mask_d;
`endif

    // Requests eligible for arbitration
    logic [N-1:0] elig;
`ifdef MUTEX_ARB_TIMEOUT_EN
    assign elig = req & ~mask_q;
`else
    assign elig = req;
`endif

    // Round-robin pick: first eligible bit at or above ptr, wrapping mod N
    logic           found;
    logic [IDW-1:0] sel_idx;
    logic [IDW-1:0] cand;
    int unsigned    pos;

    always_comb begin
        found   = 1'b0;
        sel_idx = '0;
        cand    = '0;
        pos     = 0;
        for (int unsigned i = 0; i < N; i++) begin
            pos = 32'(ptr_q) + i;
            if (pos >= N) begin
                pos = pos - N;
            end
            cand = IDW'(pos);
            if (!found && elig[cand]) begin
                found   = 1'b1;
                sel_idx = cand;
            end
        end
    end

    // Successor of the current owner, wrapping at N-1 (N need not be 2^k)
    logic [IDW-1:0] next_ptr;
    assign next_ptr = (owner_q == IDW'(N - 1)) ? '0 : owner_q + IDW'(1);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            gcnt_q     <= '0;
            gnt_q      <= '0;
            busy_q     <= 1'b0;
            owner_q    <= '0;
            conflict_q <= 1'b0;
            terr_q     <= 1'b0;
`ifdef MUTEX_ARB_TIMEOUT_EN
            hold_q     <= '0;
            mask_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            gcnt_q     <= gcnt_d;
            gnt_q      <= gnt_d;
            busy_q     <= busy_d;
            owner_q    <= owner_d;
            conflict_q <= conflict_d;
            terr_q     <= terr_d;
`ifdef MUTEX_ARB_TIMEOUT_EN
            hold_q     <= hold_d;
            mask_q     <= mask_d;
`endif
        end
    end

    // Next-state and output logic
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        gcnt_d     = gcnt_q;
        gnt_d      = gnt_q;
        busy_d     = busy_q;
        owner_d    = owner_q;
        conflict_d = 1'b0;
        terr_d     = 1'b0;
`ifdef MUTEX_ARB_TIMEOUT_EN
        hold_d     = hold_q;
        // A mask bit clears once its req has been sampled low
        mask_d     = mask_q & req;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (found) begin
                    gnt_d      = N'(1) << sel_idx;
                    owner_d    = sel_idx;
                    busy_d     = 1'b1;
                    state_d    = ST_GRANT;
                    conflict_d = ($countones(req) > 1);
`ifdef MUTEX_ARB_TIMEOUT_EN
                    hold_d     = '0;
`endif
                end
            end

            ST_GRANT: begin
                if (!req[owner_q]) begin
                    gnt_d  = '0;
                    busy_d = 1'b0;
                    ptr_d  = next_ptr;
                    if (GUARD > 0) begin
                        state_d = ST_GAP;
                        gcnt_d  = GCW'(GUARD);
                    end else begin
                        state_d = ST_IDLE;
                    end
`ifdef MUTEX_ARB_TIMEOUT_EN
                end else if (hold_q == TOW'(TIMEOUT - 1)) begin
                    // Hold count reaches TIMEOUT on this edge: revoke
                    gnt_d           = '0;
                    busy_d          = 1'b0;
                    ptr_d           = next_ptr;
                    terr_d          = 1'b1;
                    mask_d[owner_q] = 1'b1;
                    if (GUARD > 0) begin
                        state_d = ST_GAP;
                        gcnt_d  = GCW'(GUARD);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    hold_d = hold_q + TOW'(1);
`endif
                end
            end

            ST_GAP: begin
                // GUARD cycles spent here, no arbitration
                if (gcnt_q <= GCW'(1)) begin
                    gcnt_d  = '0;
                    state_d = ST_IDLE;
                end else begin
                    gcnt_d = gcnt_q - GCW'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign gnt         = gnt_q;
    assign busy        = busy_q;
    assign owner       = owner_q;
    assign conflict    = conflict_q;
    assign timeout_err = terr_q;

endmodule
